// File: rtl/hex_display_scan.sv
// Eight-digit time-multiplexed seven-segment scanner for a common-anode display.
// Register inputs are captured once per frame so a frame never mixes old and new values.
module hex_display_scan #(
  parameter int DIV   = 50000,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s1,
  input  logic [7:0] s2,
  input  logic [7:0] s3,
  input  logic [7:0] s4,
  input  logic [7:0] dp_mask,
  input  logic       en,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int             PW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  DIV_M1  = PW'(DIV - 1);
  localparam logic [PW-1:0]  BLANK_C = PW'(BLANK);

  logic [PW-1:0] pcnt;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic [7:0]    shadow_dp;
  logic          load_pend;

  logic          tick;
  logic          load;
  logic          anode_on;
  logic [3:0]    nibble;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  // Active-low font, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    f = 7'h7F;
    case (n)
      4'h0: f = 7'h40;
      4'h1: f = 7'h79;
      4'h2: f = 7'h24;
      4'h3: f = 7'h30;
      4'h4: f = 7'h19;
      4'h5: f = 7'h12;
      4'h6: f = 7'h02;
      4'h7: f = 7'h78;
      4'h8: f = 7'h00;
      4'h9: f = 7'h10;
      4'hA: f = 7'h08;
      4'hB: f = 7'h03;
      4'hC: f = 7'h46;
      4'hD: f = 7'h21;
      4'hE: f = 7'h06;
      4'hF: f = 7'h0E;
      default: f = 7'h7F;
    endcase
    return f;
  endfunction

  assign tick = (pcnt == DIV_M1);
  // A pending post-reset load and an end-of-frame load collapse into one load.
  assign load = load_pend | (tick & (idx == 3'd7));

  // NOTE: every signal driven here gets a value first, so no path can infer a latch.
  always_comb begin
    anode_on = 1'b0;
    nibble   = 4'h0;
    an_next  = 8'hFF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;

    anode_on = en && (pcnt >= BLANK_C);
    nibble   = shadow[{idx, 2'b00} +: 4];
    seg_next = font(nibble);
    if (anode_on) begin
      an_next = ~(8'h01 << idx);
      dp_next = ~shadow_dp[idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt      <= '0;
      idx       <= 3'd0;
      shadow    <= 32'h0;
      shadow_dp <= 8'h00;
      load_pend <= 1'b1;
      an        <= 8'hFF;
      seg       <= 7'h7F;
      dp        <= 1'b1;
      frame     <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) idx <= idx + 3'd1;

      if (load) begin
        shadow    <= {s4, s3, s2, s1};
        shadow_dp <= dp_mask;
      end
      load_pend <= 1'b0;
      frame     <= load;

      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with DIV=4, BLANK=1 (32-cycle frames).
// cyc counts rising edges since the last reset release; outputs after edge n reflect state n-1.
module tb_hex_display_scan;

  localparam int DIV   = 4;
  localparam int BLANK = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s1 = 8'h00, s2 = 8'h00, s3 = 8'h00, s4 = 8'h00;
  logic [7:0] dp_mask = 8'h00;
  logic       en = 1'b1;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] digits [8];

  hex_display_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4),
    .dp_mask(dp_mask), .en(en),
    .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic tick_clk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int slot_of(input int n);
    return ((n - 1) / DIV) % 8;
  endfunction

  function automatic bit on_of(input int n, input logic e);
    return (e == 1'b1) && (((n - 1) % DIV) >= BLANK);
  endfunction

  function automatic logic [7:0] exp_an(input int n, input logic e);
    logic [7:0] one;
    one = 8'h01;
    return on_of(n, e) ? ~(one << slot_of(n)) : 8'hFF;
  endfunction

  function automatic logic exp_frame(input int n);
    return (n == 1) || (n % 32 == 0);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    s1 = 8'h21; s2 = 8'h43; s3 = 8'h65; s4 = 8'h87;
    dp_mask = 8'h00; en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (an !== 8'hFF) $display("FAIL reset_an: got %h want ff", an); else passed++;
    total++; if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg); else passed++;
    total++; if (dp !== 1'b1) $display("FAIL reset_dp: got %b want 1", dp); else passed++;
    total++; if (frame !== 1'b0) $display("FAIL reset_frame: got %b want 0", frame); else passed++;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic test_first_frame();
    digits = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    for (int k = 0; k < 32; k++) begin
      tick_clk();
      total++; if (frame !== exp_frame(cyc)) $display("FAIL first_frame_pulse cyc %0d: got %b want %b", cyc, frame, exp_frame(cyc)); else passed++;
      total++; if (an !== exp_an(cyc, en)) $display("FAIL first_an cyc %0d: got %h want %h", cyc, an, exp_an(cyc, en)); else passed++;
      if (on_of(cyc, en)) begin
        total++; if (seg !== font_tab[digits[slot_of(cyc)]]) $display("FAIL first_seg cyc %0d: got %h want %h", cyc, seg, font_tab[digits[slot_of(cyc)]]); else passed++;
      end
      total++; if (dp !== 1'b1) $display("FAIL first_dp cyc %0d: got %b want 1", cyc, dp); else passed++;
    end
  endtask

  task automatic test_frame_consistency();
    for (int k = 0; k < 64; k++) begin
      tick_clk();
      if (cyc == 65) begin
        digits[0] = 4'hC;
        digits[1] = 4'hF;
      end
      total++; if (frame !== exp_frame(cyc)) $display("FAIL consist_pulse cyc %0d: got %b want %b", cyc, frame, exp_frame(cyc)); else passed++;
      total++; if (an !== exp_an(cyc, en)) $display("FAIL consist_an cyc %0d: got %h want %h", cyc, an, exp_an(cyc, en)); else passed++;
      if (on_of(cyc, en)) begin
        total++; if (seg !== font_tab[digits[slot_of(cyc)]]) $display("FAIL consist_seg cyc %0d: got %h want %h", cyc, seg, font_tab[digits[slot_of(cyc)]]); else passed++;
      end
      total++; if (dp !== 1'b1) $display("FAIL consist_dp cyc %0d: got %b want 1", cyc, dp); else passed++;
      if (cyc == 44) s1 = 8'hFC;       // idx is 3 here: mid-frame change
      if (cyc == 64) dp_mask = 8'hFF;  // captured at the end of frame 3
    end
  endtask

  task automatic test_enable();
    en = 1'b0;
    dp_mask = 8'h04;
    for (int k = 0; k < 32; k++) begin
      tick_clk();
      total++; if (an !== 8'hFF) $display("FAIL disabled_an cyc %0d: got %h want ff", cyc, an); else passed++;
      total++; if (dp !== 1'b1) $display("FAIL disabled_dp cyc %0d: got %b want 1", cyc, dp); else passed++;
      total++; if (frame !== exp_frame(cyc)) $display("FAIL disabled_pulse cyc %0d: got %b want %b", cyc, frame, exp_frame(cyc)); else passed++;
    end
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick_clk();
      total++; if (an !== exp_an(cyc, en)) $display("FAIL reenable_an cyc %0d: got %h want %h", cyc, an, exp_an(cyc, en)); else passed++;
      if (on_of(cyc, en)) begin
        total++; if (seg !== font_tab[digits[slot_of(cyc)]]) $display("FAIL reenable_seg cyc %0d: got %h want %h", cyc, seg, font_tab[digits[slot_of(cyc)]]); else passed++;
      end
    end
  endtask

  task automatic test_decimal_points();
    logic want_dp;
    for (int k = 0; k < 24; k++) begin
      tick_clk();
      want_dp = (on_of(cyc, en) && slot_of(cyc) == 2) ? 1'b0 : 1'b1;
      total++; if (an !== exp_an(cyc, en)) $display("FAIL dp_an cyc %0d: got %h want %h", cyc, an, exp_an(cyc, en)); else passed++;
      total++; if (dp !== want_dp) $display("FAIL dp_value cyc %0d: got %b want %b", cyc, dp, want_dp); else passed++;
    end
  endtask

  task automatic test_async_reset();
    repeat (22) tick_clk();
    total++; if (an !== 8'hDF) $display("FAIL pre_reset_an cyc %0d: got %h want df", cyc, an); else passed++;
    #2;
    reset = 1'b0;
    s1 = 8'h10; s2 = 8'h32; s3 = 8'h54; s4 = 8'h76;
    dp_mask = 8'h00;
    #1;
    total++; if (an !== 8'hFF) $display("FAIL async_an: got %h want ff", an); else passed++;
    total++; if (seg !== 7'h7F) $display("FAIL async_seg: got %h want 7f", seg); else passed++;
    total++; if (frame !== 1'b0) $display("FAIL async_frame: got %b want 0", frame); else passed++;
    total++; if (dp !== 1'b1) $display("FAIL async_dp: got %b want 1", dp); else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++; if (an !== 8'hFF) $display("FAIL held_reset_an: got %h want ff", an); else passed++;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    digits = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    for (int k = 0; k < 4; k++) begin
      tick_clk();
      total++; if (frame !== exp_frame(cyc)) $display("FAIL restart_pulse cyc %0d: got %b want %b", cyc, frame, exp_frame(cyc)); else passed++;
      total++; if (an !== exp_an(cyc, en)) $display("FAIL restart_an cyc %0d: got %h want %h", cyc, an, exp_an(cyc, en)); else passed++;
      if (on_of(cyc, en)) begin
        total++; if (seg !== font_tab[digits[slot_of(cyc)]]) $display("FAIL restart_seg cyc %0d: got %h want %h", cyc, seg, font_tab[digits[slot_of(cyc)]]); else passed++;
      end
      if (cyc == 1) begin
        s1 = 8'h98; s2 = 8'hBA; s3 = 8'hDC; s4 = 8'hFE;
      end
    end
  endtask

  task automatic test_font_sweep();
    for (int k = 0; k < 60; k++) begin
      tick_clk();
      if (cyc == 33) digits = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
      total++; if (frame !== exp_frame(cyc)) $display("FAIL sweep_pulse cyc %0d: got %b want %b", cyc, frame, exp_frame(cyc)); else passed++;
      total++; if (an !== exp_an(cyc, en)) $display("FAIL sweep_an cyc %0d: got %h want %h", cyc, an, exp_an(cyc, en)); else passed++;
      if (on_of(cyc, en)) begin
        total++; if (seg !== font_tab[digits[slot_of(cyc)]]) $display("FAIL sweep_seg cyc %0d: got %h want %h", cyc, seg, font_tab[digits[slot_of(cyc)]]); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_frame_consistency();
    test_enable();
    test_decimal_points();
    test_async_reset();
    test_font_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
